// File: rtl/mul_dispatch_pkg.sv
// Shared types for the multiply dispatch shim: FSM state encoding and the
// queued request entry (operands plus destination tag).
package mul_dispatch_pkg;

  localparam int unsigned mul_width     = 32;
  localparam int unsigned mul_tag_width = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } e_mul_dispatch_state;

  typedef struct packed {
    logic [mul_width-1:0]     a;
    logic [mul_width-1:0]     b;
    logic [mul_tag_width-1:0] tag;
  } mul_req_entry_t;

endpackage

// File: rtl/mul_pipeline_32bit.sv
// Iterative radix-4 32-bit multiplier: accepts a one-cycle req while idle and
// returns the low 32 product bits with a one-cycle ack 16 iterations later.
module mul_pipeline_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] product,
  output logic        ack
);

  logic        running;
  logic [3:0]  iter;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic [31:0] ma;
  logic [31:0] mb;

  always_comb begin
    acc_next = acc;
    if (mb[0]) acc_next = acc_next + ma;
    if (mb[1]) acc_next = acc_next + {ma[30:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      iter    <= '0;
      acc     <= '0;
      ma      <= '0;
      mb      <= '0;
      product <= '0;
      ack     <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (!running) begin
        if (req) begin
          running <= 1'b1;
          iter    <= '0;
          acc     <= '0;
          ma      <= a;
          mb      <= b;
        end
      end else begin
        acc  <= acc_next;
        ma   <= {ma[29:0], 2'b00};
        mb   <= {2'b00, mb[31:2]};
        iter <= iter + 1'b1;
        if (iter == 4'd15) begin
          running <= 1'b0;
          ack     <= 1'b1;
          product <= acc_next;
        end
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset; depth must be a power
// of two so the pointers wrap naturally. A push while full or a pop while empty is dropped.
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wr_data,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int unsigned aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (aw + 1)'(depth));
  assign empty   = (count == '0);

endmodule

// File: rtl/mul_dispatch_32bit.sv
// Decode-to-writeback shim around the iterative multiplier: queue, issue one
// op at a time, hold the tagged result. MUL_DISPATCH_BYPASS_EN lets an idle,
// empty shim issue an incoming request directly, skipping the FIFO.
module mul_dispatch_32bit
  import mul_dispatch_pkg::*;
#(
  parameter int unsigned width     = mul_width,
  parameter int unsigned depth     = 4,
  parameter int unsigned tag_width = mul_tag_width
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     in_a,
  input  logic [width-1:0]     in_b,
  input  logic [tag_width-1:0] in_tag,
  output logic                 mul_req,
  output logic [width-1:0]     mul_a,
  output logic [width-1:0]     mul_b,
  input  logic [width-1:0]     mul_out,
  input  logic                 mul_ack,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [width-1:0]     res_data,
  output logic [tag_width-1:0] res_tag,
  output logic                 busy
);

  localparam int unsigned cw = $clog2(depth) + 1;

  // The queued entry layout is fixed by the package; reject mismatched builds.
  if (width != mul_width || tag_width != mul_tag_width || depth < 2 ||
      (depth & (depth - 1)) != 0) begin : g_cfg_check
    $error("mul_dispatch_32bit: unsupported width/tag_width/depth");
  end

  e_mul_dispatch_state state;
  e_mul_dispatch_state state_next;
  mul_req_entry_t      in_entry;
  mul_req_entry_t      head;
  mul_req_entry_t      issue_entry;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [cw-1:0]       fifo_count;
  logic                slot_free;
  logic                bypass_take;
  logic                issue;
  logic [tag_width-1:0] inflight_tag;

  assign in_entry  = '{a: in_a, b: in_b, tag: in_tag};
  assign in_ready  = !fifo_full;
  // A result being drained this cycle frees the slot for the next issue.
  assign slot_free = !res_valid || res_ready;

`ifdef MUL_DISPATCH_BYPASS_EN
  assign bypass_take = (state == IDLE) && fifo_empty && slot_free && in_valid;
`else
  assign bypass_take = 1'b0;
`endif

  assign issue_entry = fifo_empty ? in_entry : head;
  assign fifo_push   = in_valid && in_ready && !bypass_take;
  assign fifo_pop    = issue && !fifo_empty;

  sync_fifo #(
    .width ($bits(mul_req_entry_t)),
    .depth (depth)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (in_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (slot_free && (!fifo_empty || bypass_take)) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mul_ack) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_req      <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      inflight_tag <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_tag      <= '0;
    end else begin
      mul_req <= issue;
      if (issue) begin
        mul_a        <= issue_entry.a;
        mul_b        <= issue_entry.b;
        inflight_tag <= issue_entry.tag;
      end
      if (state == WAIT && mul_ack) begin
        res_valid <= 1'b1;
        res_data  <= mul_out;
        res_tag   <= inflight_tag;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign busy = (fifo_count != '0) || (state == WAIT) || res_valid;

`ifndef SYNTHESIS
  // An ack with nothing in flight is a multiplier protocol error.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(mul_ack && state == IDLE));
  end
`endif

endmodule

// File: tb/tb_mul_dispatch_32bit.sv
// Self-checking bench for mul_dispatch_32bit driving the real iterative
// multiplier; results are scored against a queue of a*b products in accept order.
module tb_mul_dispatch_32bit;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } rec_t;

`ifdef MUL_DISPATCH_BYPASS_EN
  localparam int exp_issue_lat = 1;
`else
  localparam int exp_issue_lat = 2;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        mul_req;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_out;
  logic        mul_ack;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   req_pulses = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  mul_dispatch_32bit #(.width(32), .depth(4), .tag_width(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_req   (mul_req),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_out   (mul_out),
    .mul_ack   (mul_ack),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_tag   (res_tag),
    .busy      (busy)
  );

  mul_pipeline_32bit u_mul (
    .clk     (clk),
    .rst     (rst),
    .req     (mul_req),
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_out),
    .ack     (mul_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each accepted request yields a*b (low 32 bits) in order;
  // a reset throws away everything not yet written back.
  always @(negedge clk) begin : monitor
    logic [31:0] p;
    if (rst) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        p = in_a * in_b;
        exp_q.push_back('{d: p, t: in_tag});
      end
      if (res_valid && res_ready) got_q.push_back('{d: res_data, t: res_tag});
      if (mul_req) req_pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stuck low for tag %0d", tag);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 1000);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%b required 0", name, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic score(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got %0d results required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_result[%0d] got data=%h tag=%0d required data=%h tag=%0d",
                 name, i, got_q[i].d, got_q[i].t, exp_q[i].d, exp_q[i].t);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mul_req, res_valid, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got in_ready/mul_req/res_valid/busy=%b required 1000",
               {in_ready, mul_req, res_valid, busy});
    end
    checks++;
    if ({res_data, res_tag, mul_a, mul_b} !== '0) begin
      errors++;
      $display("FAIL reset_data got res_data=%h res_tag=%0d mul_a=%h mul_b=%h required all 0",
               res_data, res_tag, mul_a, mul_b);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n = 0;
    int p0;
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    p0 = req_pulses;
    send(32'd7, 32'd6, 5'd3);
    do begin
      @(negedge clk);
      n++;
    end while (!mul_req && n < 50);
    checks++;
    if (!(mul_req === 1'b1 && n == exp_issue_lat)) begin
      errors++;
      $display("FAIL single_issue_latency got %0d cycles (mul_req=%b) required %0d",
               n, mul_req, exp_issue_lat);
    end
    checks++;
    if (mul_a !== 32'd7 || mul_b !== 32'd6) begin
      errors++;
      $display("FAIL single_operands got a=%0d b=%0d required a=7 b=6", mul_a, mul_b);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 100);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd42 || res_tag !== 5'd3) begin
      errors++;
      $display("FAIL single_result got valid=%b data=%0d tag=%0d required valid=1 data=42 tag=3",
               res_valid, res_data, res_tag);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after_handshake got res_valid=%b busy=%b required 0 0", res_valid, busy);
    end
    checks++;
    if (req_pulses - p0 != 1) begin
      errors++;
      $display("FAIL single_req_pulses got %0d required 1", req_pulses - p0);
    end
    @(posedge clk);
    #1;
    score("single");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(32'(i + 1), 32'd3, 5'(i + 1));
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got in_ready=%b required 0", in_ready);
    end
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1 || mul_req !== 1'b1 || mul_a !== 32'd2) begin
      errors++;
      $display("FAIL b2b_reopen got in_ready=%b mul_req=%b mul_a=%0d required 1 1 2",
               in_ready, mul_req, mul_a);
    end
    @(posedge clk);
    #1;
    wait_idle("b2b");
    score("b2b");
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== 32'(3 * (i + 1)) || got_q[i].t !== 5'(i + 1)) begin
        errors++;
        $display("FAIL b2b_const[%0d] got data=%0d tag=%0d required data=%0d tag=%0d",
                 i, got_q[i].d, got_q[i].t, 3 * (i + 1), i + 1);
      end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    exp_q.delete(); got_q.delete();
    res_ready = 1'b0;
    send(32'd11, 32'd13, 5'd7);
    send(32'd5, 32'd5, 5'd8);
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 100);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd143 || res_tag !== 5'd7 || mul_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got valid=%b data=%0d tag=%0d mul_req=%b required 1 143 7 0",
                 c, res_valid, res_data, res_tag, mul_req);
      end
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mul_req !== 1'b1 || mul_a !== 32'd5 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got mul_req=%b mul_a=%0d res_valid=%b required 1 5 0",
               mul_req, mul_a, res_valid);
    end
    @(posedge clk);
    #1;
    wait_idle("stall");
    score("stall");
  endtask

  task automatic test_overflow();
    logic [31:0] req_d [3];
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    req_d[0] = 32'hFFFF_FFFE;
    req_d[1] = 32'h0000_0000;
    req_d[2] = 32'hFFFF_FFF1;
    send(32'hFFFF_FFFF, 32'd2, 5'd20);
    send(32'h8000_0000, 32'h8000_0000, 5'd21);
    send(32'hFFFF_FFFD, 32'd5, 5'd22);
    wait_idle("ovf");
    score("ovf");
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].d !== req_d[i]) begin
        errors++;
        $display("FAIL ovf_const[%0d] got %h required %h", i, got_q[i].d, req_d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    exp_q.delete(); got_q.delete();
    res_ready = 1'b1;
    send(32'd123, 32'd456, 5'd9);
    send(32'd77, 32'd2, 5'd11);
    do begin
      @(negedge clk);
      n++;
    end while (!mul_req && n < 50);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got res_valid=%b in_ready=%b busy=%b required 0 1 0",
               res_valid, in_ready, busy);
    end
    @(posedge clk);
    #1;
    send(32'd9, 32'd9, 5'd10);
    wait_idle("midreset");
    score("midreset");
    checks++;
    if (got_q.size() != 1 || got_q[0].d !== 32'd81 || got_q[0].t !== 5'd10) begin
      errors++;
      $display("FAIL midreset_result got %0d results, first data=%0d tag=%0d required one result 81 tag 10",
               got_q.size(), got_q.size() > 0 ? got_q[0].d : 32'd0, got_q.size() > 0 ? got_q[0].t : 5'd0);
    end
  endtask

  task automatic test_random();
    bit done = 1'b0;
    exp_q.delete(); got_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] a;
          logic [31:0] b;
          a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
          send(a, b, 5'($urandom_range(0, 31)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          res_ready = ($urandom_range(0, 3) != 0);
        end
        res_ready = 1'b1;
      end
    join
    wait_idle("random");
    score("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
